arbiter_pamieci_danych: RTL

//  Shares the single-port data memory (pamiec_data) between two requesters:
//  the CPU core (req 0, normally ID/Akumulator-driven) and an auxiliary master
//  (req 1, e.g. loader/DMA). Fixed CPU priority, anti-starvation for AUX, and
//  an optional bounded lock for multi-cycle bursts. Sits between both masters
//  and the memory's wr_mem/adres/dane/out pins.

---
 rtl/arbiter_pamieci_danych_if.sv | 25 ++
 rtl/arbiter_pamieci_danych.sv | 131 +++++++++++++
 2 files changed

// File: rtl/arbiter_pamieci_danych_if.sv
// One requester port of the data-memory arbiter: request/write/lock/address/data
// towards the arbiter, same-cycle grant and 1-cycle registered read data back.
interface arbiter_pamieci_danych_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdat;
    logic              gnt;
    logic [DATA_W-1:0] rdat;
    logic              rvld;

    modport master (
        output req, we, lock, adr, wdat,
        input  gnt, rdat, rvld
    );

    modport slave (
        input  req, we, lock, adr, wdat,
        output gnt, rdat, rvld
    );
endinterface

// File: rtl/arbiter_pamieci_danych.sv
// Shares single-port pamiec_data between CPU (priority) and AUX with starvation guard and bounded lock.
// Grant and memory access in the same cycle, read data 1 cycle later; a loser simply stays un-granted.
module arbiter_pamieci_danych #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    arbiter_pamieci_danych_if.slave cpu_if,
    arbiter_pamieci_danych_if.slave aux_if,
    output logic                 o_mem_wr,
    output logic [ADDR_W-1:0]    o_mem_adr,
    output logic [DATA_W-1:0]    o_mem_wdat,
    input  logic [DATA_W-1:0]    i_mem_rdat,
    output logic [7:0]           o_konflikty
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [WW-1:0] WAIT_TOP = WW'(MAX_WAIT);
    localparam logic [LW-1:0] LOCK_TOP = LW'(LOCK_MAX);

    typedef enum logic [1:0] {S_IDLE, S_OWN_CPU, S_OWN_AUX} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LW-1:0]     r_lock_cnt;
    logic [LW-1:0]     w_lock_nxt;
    logic [WW-1:0]     r_wait_cnt;
    logic [7:0]        r_konflikty;
    logic [DATA_W-1:0] r_rdat_cpu;
    logic [DATA_W-1:0] r_rdat_aux;
    logic              r_rvld_cpu;
    logic              r_rvld_aux;
    logic              w_hold_cpu;
    logic              w_hold_aux;
    logic              w_gnt_cpu;
    logic              w_gnt_aux;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        w_lock_nxt  = '0;
        if (w_gnt_cpu && cpu_if.lock) begin
            w_state_nxt = S_OWN_CPU;
        end else if (w_gnt_aux && aux_if.lock) begin
            w_state_nxt = S_OWN_AUX;
        end
        // A fresh ownership (including a re-win after LOCK_MAX) restarts at 1.
        if (w_state_nxt != S_IDLE) begin
            w_lock_nxt = (w_hold_cpu || w_hold_aux) ? r_lock_cnt + LW'(1) : LW'(1);
        end
    end

    always_comb begin
        w_hold_cpu = (r_state == S_OWN_CPU) && cpu_if.req && (r_lock_cnt < LOCK_TOP);
        w_hold_aux = (r_state == S_OWN_AUX) && aux_if.req && (r_lock_cnt < LOCK_TOP);
        w_gnt_cpu  = 1'b0;
        w_gnt_aux  = 1'b0;
        o_mem_wr   = 1'b0;
        o_mem_adr  = '0;
        o_mem_wdat = '0;
        if (i_rst) begin
            w_gnt_cpu = 1'b0;
        end else if (w_hold_cpu) begin
            w_gnt_cpu = 1'b1;
        end else if (w_hold_aux) begin
            w_gnt_aux = 1'b1;
        end else if (aux_if.req && (!cpu_if.req || r_wait_cnt == WAIT_TOP)) begin
            w_gnt_aux = 1'b1;
        end else if (cpu_if.req) begin
            w_gnt_cpu = 1'b1;
        end
        if (w_gnt_cpu) begin
            o_mem_wr   = cpu_if.we;
            o_mem_adr  = cpu_if.adr;
            o_mem_wdat = cpu_if.wdat;
        end else if (w_gnt_aux) begin
            o_mem_wr   = aux_if.we;
            o_mem_adr  = aux_if.adr;
            o_mem_wdat = aux_if.wdat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt  <= '0;
            r_konflikty <= '0;
            r_rdat_cpu  <= '0;
            r_rdat_aux  <= '0;
            r_rvld_cpu  <= 1'b0;
            r_rvld_aux  <= 1'b0;
        end else begin
            if (aux_if.req && !w_gnt_aux) begin
                r_wait_cnt <= (r_wait_cnt == WAIT_TOP) ? r_wait_cnt : r_wait_cnt + WW'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (cpu_if.req && aux_if.req && r_konflikty != 8'hFF) begin
                r_konflikty <= r_konflikty + 8'd1;
            end
            r_rvld_cpu <= w_gnt_cpu && !cpu_if.we;
            r_rvld_aux <= w_gnt_aux && !aux_if.we;
            if (w_gnt_cpu && !cpu_if.we) begin
                r_rdat_cpu <= i_mem_rdat;
            end
            if (w_gnt_aux && !aux_if.we) begin
                r_rdat_aux <= i_mem_rdat;
            end
        end
    end

    // Reset landing right after a read grant must hide that pending response.
    assign cpu_if.gnt  = w_gnt_cpu;
    assign aux_if.gnt  = w_gnt_aux;
    assign cpu_if.rvld = r_rvld_cpu && !i_rst;
    assign aux_if.rvld = r_rvld_aux && !i_rst;
    assign cpu_if.rdat = i_rst ? '0 : r_rdat_cpu;
    assign aux_if.rdat = i_rst ? '0 : r_rdat_aux;
    assign o_konflikty = r_konflikty;
endmodule
